// File: rtl/branch_predictor_btb.sv
// Bimodal / gshare branch predictor: a table of 2-bit saturating counters with a
// combinational lookup, a branch-target adder and resolution statistics.
module branch_predictor_btb #(
    parameter int ENTRIES = 16,
    parameter int MODE    = 0,
    parameter int HIST_W  = 4,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             lookup_is_branch_i,
    input  logic [31:0]      lookup_pc_i,
    input  logic [31:0]      lookup_offset_i,
    output logic             predict_o,
    output logic [31:0]      predict_target_o,
    output logic [IDX_W-1:0] predict_idx_o,
    input  logic             update_valid_i,
    input  logic [IDX_W-1:0] update_idx_i,
    input  logic             update_taken_i,
    input  logic             update_pred_i,
    input  logic             flush_i,
    input  logic             clr_stats_i,
    output logic [31:0]      branch_cnt_o,
    output logic [31:0]      mispredict_cnt_o
);

    logic [1:0]        ctr_r [ENTRIES];
    logic [HIST_W-1:0] ghr_r;
    logic [HIST_W-1:0] ghr_shift_s;
    logic [IDX_W-1:0]  pc_idx_s;
    logic [IDX_W-1:0]  hist_idx_s;
    logic [IDX_W-1:0]  lookup_idx_s;
    logic [31:0]       branch_cnt_r;
    logic [31:0]       mispredict_cnt_r;

    function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    assign pc_idx_s   = lookup_pc_i[IDX_W+1:2];
    assign hist_idx_s = IDX_W'(ghr_r);

    // Index selection: PC bits alone, or PC bits folded with global history.
    always_comb begin
        lookup_idx_s = pc_idx_s;
        if (MODE == 1) begin
            lookup_idx_s = pc_idx_s ^ hist_idx_s;
        end else begin
            lookup_idx_s = pc_idx_s;
        end
    end

    // A 1-bit history has no older bits to keep, so it simply takes the outcome.
    generate
        if (HIST_W == 1) begin : g_hist1
            assign ghr_shift_s = update_taken_i;
        end else begin : g_histn
            assign ghr_shift_s = {ghr_r[HIST_W-2:0], update_taken_i};
        end
    endgenerate

    // Reads come straight from the table, so a same-cycle update is never visible here.
    assign predict_o        = lookup_is_branch_i & ctr_r[lookup_idx_s][1];
    assign predict_target_o = lookup_pc_i + lookup_offset_i;
    assign predict_idx_o    = lookup_idx_s;
    assign branch_cnt_o     = branch_cnt_r;
    assign mispredict_cnt_o = mispredict_cnt_r;

    // Counter table: weakly-not-taken after reset or flush, saturating training otherwise.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= 2'b01;
            end
        end else if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= 2'b01;
            end
        end else if (update_valid_i) begin
            ctr_r[update_idx_i] <= sat_next(ctr_r[update_idx_i], update_taken_i);
        end
    end

    // Global history register, shifted on every resolved branch in either mode.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ghr_r <= {HIST_W{1'b0}};
        end else if (flush_i) begin
            ghr_r <= {HIST_W{1'b0}};
        end else if (update_valid_i) begin
            ghr_r <= ghr_shift_s;
        end else begin
            ghr_r <= ghr_r;
        end
    end

    // Statistics keep counting through a flush; only reset or clear zeroes them.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            branch_cnt_r     <= 32'd0;
            mispredict_cnt_r <= 32'd0;
        end else if (clr_stats_i) begin
            branch_cnt_r     <= 32'd0;
            mispredict_cnt_r <= 32'd0;
        end else if (update_valid_i) begin
            branch_cnt_r <= branch_cnt_r + 32'd1;
            if (update_pred_i != update_taken_i) begin
                mispredict_cnt_r <= mispredict_cnt_r + 32'd1;
            end else begin
                mispredict_cnt_r <= mispredict_cnt_r;
            end
        end else begin
            branch_cnt_r     <= branch_cnt_r;
            mispredict_cnt_r <= mispredict_cnt_r;
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: a bimodal and a gshare instance share
// all inputs; expectations are queued when stimulus is driven and checked on output.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        rstn;
    logic        lookup_is_branch;
    logic [31:0] lookup_pc;
    logic [31:0] lookup_offset;
    logic        update_valid;
    logic [3:0]  update_idx;
    logic        update_taken;
    logic        update_pred;
    logic        flush;
    logic        clr_stats;

    logic        b_predict, g_predict;
    logic [31:0] b_target, g_target;
    logic [3:0]  b_idx, g_idx;
    logic [31:0] b_br, g_br, b_mis, g_mis;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp;
    logic [31:0] br_before;
    logic [31:0] mis_before;

    always #5 clk = ~clk;

    branch_predictor_btb #(.ENTRIES(16), .MODE(0), .HIST_W(4)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .lookup_is_branch_i(lookup_is_branch), .lookup_pc_i(lookup_pc),
        .lookup_offset_i(lookup_offset),
        .predict_o(b_predict), .predict_target_o(b_target), .predict_idx_o(b_idx),
        .update_valid_i(update_valid), .update_idx_i(update_idx),
        .update_taken_i(update_taken), .update_pred_i(update_pred),
        .flush_i(flush), .clr_stats_i(clr_stats),
        .branch_cnt_o(b_br), .mispredict_cnt_o(b_mis)
    );

    branch_predictor_btb #(.ENTRIES(16), .MODE(1), .HIST_W(4)) dut_g (
        .clk_i(clk), .rstn_i(rstn),
        .lookup_is_branch_i(lookup_is_branch), .lookup_pc_i(lookup_pc),
        .lookup_offset_i(lookup_offset),
        .predict_o(g_predict), .predict_target_o(g_target), .predict_idx_o(g_idx),
        .update_valid_i(update_valid), .update_idx_i(update_idx),
        .update_taken_i(update_taken), .update_pred_i(update_pred),
        .flush_i(flush), .clr_stats_i(clr_stats),
        .branch_cnt_o(g_br), .mispredict_cnt_o(g_mis)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [3:0] idx, input logic taken, input logic pred);
        update_valid = 1'b1;
        update_idx   = idx;
        update_taken = taken;
        update_pred  = pred;
        tick();
        update_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        lookup_is_branch = 1'b1;
        lookup_pc        = pc;
        lookup_offset    = 32'd0;
    endtask

    task automatic test_reset();
        lookup(32'h0000_0014);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd5);
        #2;
        exp = exp_q.pop_front(); tests_run++;
        if ({31'd0, b_predict} !== exp) begin
            tests_failed++; $display("FAIL reset_predict got %0h want %0h", b_predict, exp);
        end
        exp = exp_q.pop_front(); tests_run++;
        if (b_br !== exp || b_mis !== exp) begin
            tests_failed++; $display("FAIL reset_stats got %0h/%0h want %0h", b_br, b_mis, exp);
        end
        exp = exp_q.pop_front(); tests_run++;
        if ({28'd0, g_idx} !== exp) begin
            tests_failed++; $display("FAIL reset_gidx got %0h want %0h", g_idx, exp);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_bimodal_sat();
        lookup(32'h0000_0014);
        upd(4'd5, 1'b1, 1'b1);
        upd(4'd5, 1'b1, 1'b1);
        upd(4'd5, 1'b1, 1'b1);
        exp_q.push_back(32'd1);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if ({31'd0, b_predict} !== exp) begin
            tests_failed++; $display("FAIL sat_3taken got %0h want %0h", b_predict, exp);
        end
        upd(4'd5, 1'b1, 1'b1);
        upd(4'd5, 1'b0, 1'b1);
        exp_q.push_back(32'd1);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if ({31'd0, b_predict} !== exp) begin
            tests_failed++; $display("FAIL sat_hold_then_nt got %0h want %0h", b_predict, exp);
        end
        upd(4'd5, 1'b0, 1'b1);
        exp_q.push_back(32'd0);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if ({31'd0, b_predict} !== exp) begin
            tests_failed++; $display("FAIL sat_2nt got %0h want %0h", b_predict, exp);
        end
    endtask

    task automatic test_target();
        lookup_is_branch = 1'b0;
        lookup_pc        = 32'h0000_0100;
        lookup_offset    = 32'hFFFF_FFF0;
        exp_q.push_back(32'h0000_00F0);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if (b_target !== exp) begin
            tests_failed++; $display("FAIL target_neg got %0h want %0h", b_target, exp);
        end
        lookup_pc     = 32'hFFFF_FFFC;
        lookup_offset = 32'd8;
        exp_q.push_back(32'h0000_0004);
        exp_q.push_back(32'hF);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if (b_target !== exp) begin
            tests_failed++; $display("FAIL target_wrap got %0h want %0h", b_target, exp);
        end
        exp = exp_q.pop_front(); tests_run++;
        if ({28'd0, b_idx} !== exp) begin
            tests_failed++; $display("FAIL idx_not_branch got %0h want %0h", b_idx, exp);
        end
    endtask

    task automatic test_gshare();
        do_flush();
        upd(4'd0, 1'b1, 1'b1);
        upd(4'd0, 1'b0, 1'b0);
        upd(4'd0, 1'b1, 1'b1);
        upd(4'd0, 1'b1, 1'b1);
        lookup(32'h0000_0040);
        exp_q.push_back(32'hB);
        exp_q.push_back(32'h0);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if ({28'd0, g_idx} !== exp) begin
            tests_failed++; $display("FAIL gshare_idx got %0h want %0h", g_idx, exp);
        end
        exp = exp_q.pop_front(); tests_run++;
        if ({28'd0, b_idx} !== exp) begin
            tests_failed++; $display("FAIL bimodal_idx got %0h want %0h", b_idx, exp);
        end
        lookup(32'h0000_0044);
        exp_q.push_back(32'hA);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if ({28'd0, g_idx} !== exp) begin
            tests_failed++; $display("FAIL gshare_idx2 got %0h want %0h", g_idx, exp);
        end
    endtask

    task automatic test_collision();
        do_flush();
        lookup(32'h0000_0008);
        update_valid = 1'b1;
        update_idx   = 4'd2;
        update_taken = 1'b1;
        update_pred  = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if ({31'd0, b_predict} !== exp) begin
            tests_failed++; $display("FAIL collide_same got %0h want %0h", b_predict, exp);
        end
        tick();
        update_valid = 1'b0;
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if ({31'd0, b_predict} !== exp) begin
            tests_failed++; $display("FAIL collide_next got %0h want %0h", b_predict, exp);
        end
    endtask

    task automatic test_stats();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        for (int i = 0; i < 10; i++) begin
            upd(4'd7, i[0], (i < 3) ? ~i[0] : i[0]);
        end
        exp_q.push_back(32'd10);
        exp_q.push_back(32'd3);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if (b_br !== exp) begin
            tests_failed++; $display("FAIL stats_branch got %0d want %0d", b_br, exp);
        end
        exp = exp_q.pop_front(); tests_run++;
        if (b_mis !== exp) begin
            tests_failed++; $display("FAIL stats_mispred got %0d want %0d", b_mis, exp);
        end
        clr_stats = 1'b1;
        upd(4'd7, 1'b1, 1'b0);
        clr_stats = 1'b0;
        exp_q.push_back(32'd0);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if (b_br !== exp || b_mis !== exp) begin
            tests_failed++; $display("FAIL stats_clr got %0d/%0d want %0d", b_br, b_mis, exp);
        end
    endtask

    task automatic test_flush();
        do_flush();
        upd(4'd3, 1'b1, 1'b1);
        lookup(32'h0000_000C);
        exp_q.push_back(32'd1);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if ({31'd0, b_predict} !== exp) begin
            tests_failed++; $display("FAIL flush_pre got %0h want %0h", b_predict, exp);
        end
        br_before  = b_br;
        mis_before = b_mis;
        flush = 1'b1;
        upd(4'd3, 1'b1, 1'b0);
        flush = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(br_before + 32'd1);
        exp_q.push_back(mis_before + 32'd1);
        exp_q.push_back(32'd0);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if ({31'd0, b_predict} !== exp) begin
            tests_failed++; $display("FAIL flush_ctr got %0h want %0h", b_predict, exp);
        end
        exp = exp_q.pop_front(); tests_run++;
        if (b_br !== exp) begin
            tests_failed++; $display("FAIL flush_branch got %0d want %0d", b_br, exp);
        end
        exp = exp_q.pop_front(); tests_run++;
        if (b_mis !== exp) begin
            tests_failed++; $display("FAIL flush_mispred got %0d want %0d", b_mis, exp);
        end
        lookup(32'h0000_0040);
        #1;
        exp = exp_q.pop_front(); tests_run++;
        if ({28'd0, g_idx} !== exp) begin
            tests_failed++; $display("FAIL flush_ghr got %0h want %0h", g_idx, exp);
        end
    endtask

    task automatic test_reset_mid();
        upd(4'd5, 1'b1, 1'b1);
        lookup(32'h0000_0014);
        update_valid = 1'b1;
        update_idx   = 4'd5;
        update_taken = 1'b1;
        update_pred  = 1'b0;
        #2;
        rstn = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd5);
        #1;
        exp = exp_q.pop_front(); tests_run++;
        if ({31'd0, b_predict} !== exp) begin
            tests_failed++; $display("FAIL rstmid_predict got %0h want %0h", b_predict, exp);
        end
        exp = exp_q.pop_front(); tests_run++;
        if (b_br !== exp || b_mis !== exp) begin
            tests_failed++; $display("FAIL rstmid_stats got %0h/%0h want %0h", b_br, b_mis, exp);
        end
        exp = exp_q.pop_front(); tests_run++;
        if ({28'd0, g_idx} !== exp) begin
            tests_failed++; $display("FAIL rstmid_gidx got %0h want %0h", g_idx, exp);
        end
        tick();
        @(negedge clk);
        update_valid = 1'b0;
        rstn = 1'b1;
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front(); tests_run++;
        if ({31'd0, b_predict} !== exp || b_br !== exp) begin
            tests_failed++; $display("FAIL rstmid_discard got %0h/%0h want %0h", b_predict, b_br, exp);
        end
        upd(4'd5, 1'b1, 1'b1);
        exp_q.push_back(32'd1);
        @(negedge clk);
        exp = exp_q.pop_front(); tests_run++;
        if ({31'd0, b_predict} !== exp || b_br !== exp) begin
            tests_failed++; $display("FAIL rst_first_update got %0h/%0h want %0h", b_predict, b_br, exp);
        end
    endtask

    initial begin
        rstn             = 1'b0;
        lookup_is_branch = 1'b0;
        lookup_pc        = 32'd0;
        lookup_offset    = 32'd0;
        update_valid     = 1'b0;
        update_idx       = 4'd0;
        update_taken     = 1'b0;
        update_pred      = 1'b0;
        flush            = 1'b0;
        clr_stats        = 1'b0;
        test_reset();
        test_bimodal_sat();
        test_target();
        test_gshare();
        test_collision();
        test_stats();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
